// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, owns the
// program counter and the IF/ID pipeline register, absorbs a returned word
// into a one-entry skid buffer when decode stalls, and handles branch
// redirects, including one that arrives while a request is still outstanding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  // KILL waits out a request that was outstanding when a redirect arrived.
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] pc_inc;
  logic [31:0] target_aligned;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign pc_inc         = pc_q + 32'd4;
  assign target_aligned = word_align(branch_target_i);

  // Next-state, PC, skid buffer and IF/ID register computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_vld_d   = skid_vld_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_vld_d   = ifid_vld_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (flush_i) begin
          ifid_vld_d = 1'b0;
          skid_vld_d = 1'b0;
          pc_d       = target_aligned;
        end
      end
      FETCH: begin
        if (flush_i) begin
          ifid_vld_d = 1'b0;
          skid_vld_d = 1'b0;
          if (imem_ready_i) begin
            pc_d    = target_aligned;
            state_d = FETCH;
          end else begin
            redirect_d = target_aligned;
            state_d    = KILL;
          end
        end else if (imem_ready_i) begin
          pc_d = pc_inc;
          if (stall_i) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_data_i;
            skid_vld_d   = 1'b1;
            state_d      = HOLD;
          end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_data_i;
            ifid_vld_d   = 1'b1;
          end
        end else if (!stall_i) begin
          // No word this cycle: hand decode a bubble, keep the old payload.
          ifid_vld_d = 1'b0;
        end
      end
      HOLD: begin
        if (flush_i) begin
          ifid_vld_d = 1'b0;
          skid_vld_d = 1'b0;
          pc_d       = target_aligned;
          state_d    = FETCH;
        end else if (!stall_i) begin
          ifid_pc_d    = skid_pc_q;
          ifid_instr_d = skid_instr_q;
          ifid_vld_d   = skid_vld_q;
          skid_vld_d   = 1'b0;
          state_d      = FETCH;
        end
      end
      KILL: begin
        // Returned data is never written to IF/ID here.
        if (flush_i) begin
          ifid_vld_d = 1'b0;
          skid_vld_d = 1'b0;
          if (imem_ready_i) begin
            pc_d    = target_aligned;
            state_d = FETCH;
          end else begin
            redirect_d = target_aligned;
          end
        end else if (imem_ready_i) begin
          pc_d    = redirect_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == FETCH) || (state_d == KILL);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      redirect_q   <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_vld_q   <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_vld_q   <= skid_vld_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign pc_o        = ifid_pc_q;
  assign instr_o     = ifid_instr_q;
  assign valid_o     = ifid_vld_q;

endmodule
